// File: rtl/ifu_fetch_unit.sv
// Instruction-fetch front end: fetch PC, aligned block requests to imem, BUF_DEPTH decode FIFO.
// Optional IFU_FETCH_BYPASS_EN presents a response on fetch_* in its arrival cycle when the FIFO is empty.
module ifu_fetch_unit #(
  parameter int XLEN        = 64,
  parameter int FETCH_WIDTH = 4,
  parameter int BUF_DEPTH   = 2,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     redirect_valid,
  input  logic [XLEN-1:0]          redirect_pc,
  output logic                     imem_req_valid,
  input  logic                     imem_req_ready,
  output logic [XLEN-1:0]          imem_req_addr,
  input  logic                     imem_resp_valid,
  input  logic [FETCH_WIDTH*32-1:0] imem_resp_data,
  output logic                     fetch_valid,
  input  logic                     fetch_ready,
  output logic [XLEN-1:0]          fetch_pc,
  output logic [FETCH_WIDTH*32-1:0] fetch_inst,
  output logic [FETCH_WIDTH-1:0]   fetch_mask
);

  localparam int BLK_BYTES = FETCH_WIDTH * 4;
  localparam int BLK_BITS  = $clog2(BLK_BYTES);
  localparam int OFF_BITS  = BLK_BITS - 2;
  localparam int OFFW      = (OFF_BITS > 0) ? OFF_BITS : 1;
  localparam int DW        = FETCH_WIDTH * 32;
  localparam int PTRW      = $clog2(BUF_DEPTH);
  localparam logic [XLEN-1:0] BLK_MASK = XLEN'(BLK_BYTES - 1);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_STALL} state_t;

  state_t           state_reg, state_next;
  logic [XLEN-1:0]  pc_reg, pc_next;
  logic [XLEN-1:0]  req_pc_reg, req_pc_next;
  logic [OFFW-1:0]  req_off_reg, req_off_next;
  logic [OFFW-1:0]  pc_off;
  logic             outstanding_reg, outstanding_next;
  logic             drop_reg, drop_next;
  logic [PTRW-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [PTRW:0]    count_reg;

  logic [XLEN-1:0]        fifo_pc   [BUF_DEPTH];
  logic [DW-1:0]          fifo_data [BUF_DEPTH];
  logic [FETCH_WIDTH-1:0] fifo_mask [BUF_DEPTH];

  logic [XLEN-1:0]        req_addr;
  logic [FETCH_WIDTH-1:0] resp_mask;
  logic                   credit, req_valid, resp_accept;
  logic                   bypass, push, pop, fifo_empty;

  assign req_addr      = pc_reg & ~BLK_MASK;
  assign imem_req_addr = req_addr;
  assign credit        = (int'(count_reg) + int'(outstanding_reg)) < BUF_DEPTH;
  assign imem_req_valid = req_valid && rst_n;
  assign fifo_empty    = (count_reg == '0);

  generate
    if (OFF_BITS > 0) begin : g_off
      assign pc_off = pc_reg[BLK_BITS-1:2];
    end else begin : g_no_off
      assign pc_off = '0;
    end
  endgenerate

  // Slots below the entry offset of the block are not part of the fetch stream.
  generate
    for (genvar gi = 0; gi < FETCH_WIDTH; gi++) begin : g_mask
      assign resp_mask[gi] = (gi >= int'(req_off_reg));
    end
  endgenerate

  always_comb begin
    state_next       = state_reg;
    pc_next          = pc_reg;
    req_pc_next      = req_pc_reg;
    req_off_next     = req_off_reg;
    outstanding_next = outstanding_reg;
    drop_next        = drop_reg;
    req_valid        = 1'b0;
    resp_accept      = 1'b0;
    if (redirect_valid) begin
      pc_next          = redirect_pc;
      drop_next        = outstanding_reg && !imem_resp_valid;
      outstanding_next = outstanding_reg && !imem_resp_valid;
      state_next       = (outstanding_reg && !imem_resp_valid) ? S_WAIT : S_REQ;
    end else begin
      case (state_reg)
        S_REQ: begin
          if (credit) begin
            req_valid = 1'b1;
            if (imem_req_ready) begin
              outstanding_next = 1'b1;
              req_pc_next      = pc_reg;
              req_off_next     = pc_off;
              pc_next          = req_addr + XLEN'(BLK_BYTES);
              state_next       = S_WAIT;
            end
          end else begin
            state_next = S_STALL;
          end
        end
        S_WAIT: begin
          if (imem_resp_valid) begin
            outstanding_next = 1'b0;
            drop_next        = 1'b0;
            resp_accept      = !drop_reg;
            state_next       = S_REQ;
          end
        end
        S_STALL: begin
          if (credit) state_next = S_REQ;
        end
        default: state_next = S_REQ;
      endcase
    end
  end

`ifdef IFU_FETCH_BYPASS_EN
  assign bypass = resp_accept && fifo_empty;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed block that decode takes immediately never occupies a FIFO slot.
  assign push = resp_accept && !(bypass && fetch_ready);
  assign pop  = !redirect_valid && fetch_ready && !fifo_empty;
  assign fetch_valid = bypass || !fifo_empty;

  always_comb begin
    fetch_pc   = fifo_pc[rd_ptr_reg];
    fetch_inst = fifo_data[rd_ptr_reg];
    fetch_mask = fifo_mask[rd_ptr_reg];
    if (bypass) begin
      fetch_pc   = req_pc_reg;
      fetch_inst = imem_resp_data;
      fetch_mask = resp_mask;
    end
    if (!fetch_valid) fetch_mask = '0;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[wr_ptr_reg]   <= req_pc_reg;
      fifo_data[wr_ptr_reg] <= imem_resp_data;
      fifo_mask[wr_ptr_reg] <= resp_mask;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= S_REQ;
      pc_reg          <= RESET_PC;
      req_pc_reg      <= RESET_PC;
      req_off_reg     <= '0;
      outstanding_reg <= 1'b0;
      drop_reg        <= 1'b0;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      count_reg       <= '0;
    end else begin
      state_reg       <= state_next;
      pc_reg          <= pc_next;
      req_pc_reg      <= req_pc_next;
      req_off_reg     <= req_off_next;
      outstanding_reg <= outstanding_next;
      drop_reg        <= drop_next;
      if (redirect_valid) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
        count_reg  <= '0;
      end else begin
        if (push) wr_ptr_reg <= wr_ptr_reg + PTRW'(1);
        if (pop)  rd_ptr_reg <= rd_ptr_reg + PTRW'(1);
        count_reg <= count_reg + (PTRW+1)'(push) - (PTRW+1)'(pop);
      end
    end
  end

endmodule

// File: tb/tb_ifu_fetch_unit.sv
// Directed bench for ifu_fetch_unit: cycle table for request timing plus multi-cycle corner sequences.
module tb_ifu_fetch_unit;

`ifdef IFU_FETCH_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         redirect_valid;
  logic [63:0]  redirect_pc;
  logic         imem_req_valid;
  logic         imem_req_ready;
  logic [63:0]  imem_req_addr;
  logic         imem_resp_valid;
  logic [127:0] imem_resp_data;
  logic         fetch_valid;
  logic         fetch_ready;
  logic [63:0]  fetch_pc;
  logic [127:0] fetch_inst;
  logic [3:0]   fetch_mask;

  always #5 clk = ~clk;

  ifu_fetch_unit #(.XLEN(64), .FETCH_WIDTH(4), .BUF_DEPTH(2), .RESET_PC(64'h0)) dut (
    .clk(clk), .rst_n(rst_n),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready), .fetch_pc(fetch_pc),
    .fetch_inst(fetch_inst), .fetch_mask(fetch_mask)
  );

  typedef struct {
    logic        redir;
    logic [63:0] rpc;
    logic        fready;
    logic        mready;
    logic        exp_rv;
    logic [63:0] exp_addr;
  } vec_t;

  typedef struct {
    logic [63:0]  pc;
    logic [3:0]   mask;
    logic [127:0] inst;
  } del_t;

  int nvec = 0;
  int nfail = 0;
  del_t        deliv_q[$];
  logic [63:0] acc_q[$];
  int          mem_lat = 1;
  bit          mem_busy = 0;
  int          mem_cnt = 0;
  logic [63:0] mem_addr = '0;
  logic        s_rv, s_fv, s_resp;
  logic [63:0] s_addr, s_fpc;
  vec_t        tbl[17];

  function automatic logic [127:0] blk(input logic [63:0] a);
    logic [127:0] d;
    for (int i = 0; i < 4; i++) d[32*i +: 32] = (a[31:0] + 32'(i*4)) ^ 32'h5A00_0000;
    return d;
  endfunction

  function automatic logic [63:0] dpc(input int i);
    return (i < deliv_q.size()) ? deliv_q[i].pc : 64'hx;
  endfunction

  function automatic logic [3:0] dmask(input int i);
    return (i < deliv_q.size()) ? deliv_q[i].mask : 4'hx;
  endfunction

  function automatic logic [63:0] apc(input int i);
    return (i < acc_q.size()) ? acc_q[i] : 64'hx;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // One clock: sample just after the input change, then advance to the next falling edge
  // and let the memory model produce its response for the new cycle.
  task automatic cycle();
    bit acc;
    #1;
    s_rv   = imem_req_valid;
    s_addr = imem_req_addr;
    s_fv   = fetch_valid;
    s_fpc  = fetch_pc;
    s_resp = imem_resp_valid;
    acc    = imem_req_valid && imem_req_ready;
    if (acc) begin
      check("single_outstanding", 128'(mem_busy), 128'(0));
      acc_q.push_back(imem_req_addr);
    end
    if (fetch_valid && fetch_ready && !redirect_valid)
      deliv_q.push_back('{fetch_pc, fetch_mask, fetch_inst});
    @(posedge clk);
    @(negedge clk);
    imem_resp_valid = 1'b0;
    if (acc) begin
      mem_busy = 1;
      mem_cnt  = mem_lat;
      mem_addr = s_addr;
    end
    if (mem_busy) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = blk(mem_addr);
        mem_busy        = 0;
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    tbl[0]  = '{0, 64'h0,   1, 1, 1, 64'h0};
    tbl[1]  = '{0, 64'h0,   1, 1, 0, 64'h0};
    tbl[2]  = '{0, 64'h0,   1, 1, 1, 64'h10};
    tbl[3]  = '{0, 64'h0,   1, 1, 0, 64'h0};
    tbl[4]  = '{0, 64'h0,   1, 1, 1, 64'h20};
    tbl[5]  = '{0, 64'h0,   1, 1, 0, 64'h0};
    tbl[6]  = '{0, 64'h0,   1, 0, 1, 64'h30};
    tbl[7]  = '{1, 64'h108, 1, 1, 0, 64'h0};
    tbl[8]  = '{0, 64'h0,   1, 1, 1, 64'h100};
    tbl[9]  = '{0, 64'h0,   1, 1, 0, 64'h0};
    tbl[10] = '{0, 64'h0,   1, 1, 1, 64'h110};
    tbl[11] = '{0, 64'h0,   1, 1, 0, 64'h0};
    tbl[12] = '{0, 64'h0,   1, 0, 1, 64'h120};
    tbl[13] = '{0, 64'h0,   1, 0, 1, 64'h120};
    tbl[14] = '{0, 64'h0,   1, 0, 1, 64'h120};
    tbl[15] = '{0, 64'h0,   1, 1, 1, 64'h120};
    tbl[16] = '{0, 64'h0,   1, 1, 0, 64'h0};

    rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    imem_req_ready = 1'b1; imem_resp_valid = 1'b0; imem_resp_data = '0; fetch_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("reset_req_valid", 128'(imem_req_valid), 128'(0));
    check("reset_fetch_valid", 128'(fetch_valid), 128'(0));
    check("reset_fetch_mask", 128'(fetch_mask), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Sequential fetch, redirect to mid-block PC while idle, held request under imem backpressure.
    for (int i = 0; i < 17; i++) begin
      redirect_valid = tbl[i].redir;
      redirect_pc    = tbl[i].rpc;
      fetch_ready    = tbl[i].fready;
      imem_req_ready = tbl[i].mready;
      cycle();
      check($sformatf("tbl%0d_req_valid", i), 128'(s_rv), 128'(tbl[i].exp_rv));
      if (tbl[i].exp_rv) check($sformatf("tbl%0d_req_addr", i), 128'(s_addr), 128'(tbl[i].exp_addr));
    end
    redirect_valid = 1'b0;
    imem_req_ready = 1'b0;
    run(2);
    check("tbl_deliv_count", 128'(deliv_q.size()), 128'(6));
    begin
      logic [63:0] epc[6];
      logic [3:0]  emask[6];
      epc   = '{64'h0, 64'h10, 64'h20, 64'h108, 64'h110, 64'h120};
      emask = '{4'hF, 4'hF, 4'hF, 4'hC, 4'hF, 4'hF};
      for (int i = 0; i < 6; i++) begin
        check($sformatf("tbl_deliv%0d_pc", i), 128'(dpc(i)), 128'(epc[i]));
        check($sformatf("tbl_deliv%0d_mask", i), 128'(dmask(i)), 128'(emask[i]));
        if (i < deliv_q.size())
          check($sformatf("tbl_deliv%0d_inst", i), deliv_q[i].inst, blk(epc[i] & ~64'hF));
      end
    end
    check("acc_no_dup_0x120", 128'(acc_q.size()), 128'(6));

    // Redirect while the 0x130 request is outstanding: its late response must be dropped.
    deliv_q.delete(); acc_q.delete();
    mem_lat = 3;
    imem_req_ready = 1'b1;
    cycle();
    redirect_valid = 1'b1; redirect_pc = 64'h200;
    cycle();
    check("drop_redirect_req_valid", 128'(s_rv), 128'(0));
    redirect_valid = 1'b0;
    cycle();
    check("drop_wait_req_valid", 128'(s_rv), 128'(0));
    run(8);
    imem_req_ready = 1'b0;
    run(4);
    check("drop_acc0", 128'(apc(0)), 128'(64'h130));
    check("drop_acc1", 128'(apc(1)), 128'(64'h200));
    check("drop_deliv_count", 128'(deliv_q.size()), 128'(2));
    check("drop_first_pc", 128'(dpc(0)), 128'(64'h200));
    check("drop_first_mask", 128'(dmask(0)), 128'(4'hF));
    check("drop_second_pc", 128'(dpc(1)), 128'(64'h210));

    // Decode stalled: exactly two blocks buffered, then in-order drain and resume.
    deliv_q.delete(); acc_q.delete();
    mem_lat = 1;
    fetch_ready = 1'b0; imem_req_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 64'h0;
    cycle();
    redirect_valid = 1'b0;
    run(10);
    check("stall_acc_count", 128'(acc_q.size()), 128'(2));
    check("stall_req_valid", 128'(s_rv), 128'(0));
    check("stall_fetch_valid", 128'(s_fv), 128'(1));
    check("stall_fetch_pc", 128'(s_fpc), 128'(64'h0));
    fetch_ready = 1'b1;
    run(8);
    check("drain_pc0", 128'(dpc(0)), 128'(64'h0));
    check("drain_pc1", 128'(dpc(1)), 128'(64'h10));
    check("drain_pc2", 128'(dpc(2)), 128'(64'h20));
    check("resume_acc2", 128'(apc(2)), 128'(64'h20));

    // PC wrap at the top of the address space.
    imem_req_ready = 1'b0;
    run(3);
    deliv_q.delete(); acc_q.delete();
    redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFF0;
    cycle();
    redirect_valid = 1'b0;
    cycle();
    check("wrap_req_valid", 128'(s_rv), 128'(1));
    check("wrap_req_addr", 128'(s_addr), 128'(64'hFFFF_FFFF_FFFF_FFF0));
    imem_req_ready = 1'b1;
    run(6);
    imem_req_ready = 1'b0;
    run(2);
    check("wrap_acc0", 128'(apc(0)), 128'(64'hFFFF_FFFF_FFFF_FFF0));
    check("wrap_acc1", 128'(apc(1)), 128'(64'h0));
    check("wrap_deliv0", 128'(dpc(0)), 128'(64'hFFFF_FFFF_FFFF_FFF0));
    check("wrap_deliv1", 128'(dpc(1)), 128'(64'h0));

    // Response-to-decode latency with an empty FIFO.
    imem_req_ready = 1'b1;
    cycle();
    imem_req_ready = 1'b0;
    cycle();
    check("lat_resp_cycle_resp", 128'(s_resp), 128'(1));
    check("lat_resp_cycle_fvalid", 128'(s_fv), 128'(BYPASS));
    cycle();
    check("lat_next_cycle_fvalid", 128'(s_fv), 128'(!BYPASS));

    // Asynchronous reset assertion mid-cycle, then restart from RESET_PC.
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_req_valid", 128'(imem_req_valid), 128'(0));
    check("async_rst_fetch_valid", 128'(fetch_valid), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    mem_busy = 0; imem_resp_valid = 1'b0;
    cycle();
    check("restart_req_valid", 128'(s_rv), 128'(1));
    check("restart_req_addr", 128'(s_addr), 128'(64'h0));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
